// File: rtl/vx_div_multi_unit_pkg.sv
// vx_div_multi_unit_pkg: shared engine state type and width helpers for the multi-engine divider
package vx_div_multi_unit_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} eng_state_e;

    function automatic logic [63:0] div_all_ones(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] min_int(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vx_div_multi_unit_engine.sv
// vx_div_engine: one radix-2 restoring divide engine covering every lane of a warp
module vx_div_engine
    import vx_div_multi_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 4,
    parameter int TAG_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   retire,
    input  logic                   is_signed,
    input  logic                   is_rem,
    input  logic [LANES-1:0]       lane_mask,
    input  logic [LANES*WIDTH-1:0] numer,
    input  logic [LANES*WIDTH-1:0] denom,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output eng_state_e             state,
    output logic [LANES*WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]   tag
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(div_all_ones(WIDTH));

    eng_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LANES-1:0][WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d, res_q, res_d;
    logic [LANES-1:0] qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, mask_q, mask_d;
    logic rsel_q, rsel_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [LANES-1:0][WIDTH-1:0] n_abs, d_abs, nrem, nquo, fin, eo;
    logic [LANES-1:0] n_neg, d_neg, d_zero;
    logic early;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] n, d;
        logic [WIDTH:0] sh, diff;
        assign n         = numer[i*WIDTH +: WIDTH];
        assign d         = denom[i*WIDTH +: WIDTH];
        assign n_neg[i]  = is_signed & n[WIDTH-1];
        assign d_neg[i]  = is_signed & d[WIDTH-1];
        assign d_zero[i] = ~|d;
        assign n_abs[i]  = n_neg[i] ? -n : n;
        assign d_abs[i]  = d_neg[i] ? -d : d;
        assign eo[i]     = !lane_mask[i] ? '0 : (is_rem ? n : ONES);
        // shift in the next dividend bit; a borrow out of diff means the divisor does not fit
        assign sh      = {rem_q[i], quo_q[i][WIDTH-1]};
        assign diff    = sh - {1'b0, den_q[i]};
        assign nrem[i] = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        assign nquo[i] = {quo_q[i][WIDTH-2:0], ~diff[WIDTH]};
        assign fin[i]  = !mask_q[i] ? '0 :
                         rsel_q     ? (rneg_q[i] ? -nrem[i] : nrem[i]) :
                         dz_q[i]    ? ONES : (qneg_q[i] ? -nquo[i] : nquo[i]);
    end

    assign early = ~|(lane_mask & ~d_zero);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        mask_d  = mask_q;
        rsel_d  = rsel_q;
        tag_d   = tag_q;
        if (state_q == IDLE && start) begin
            state_d = early ? DONE : CALC;
            cnt_d   = CW'(WIDTH - 1);
            rem_d   = '0;
            quo_d   = n_abs;
            den_d   = d_abs;
            res_d   = eo;
            qneg_d  = n_neg ^ d_neg;
            rneg_d  = n_neg;
            dz_d    = d_zero;
            mask_d  = lane_mask;
            rsel_d  = is_rem;
            tag_d   = tag_in;
        end else if (state_q == CALC) begin
            rem_d = nrem;
            quo_d = nquo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = DONE;
                res_d   = fin;
            end
        end else if (state_q == DONE && retire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        den_q   <= den_d;
        res_q   <= res_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
        dz_q    <= dz_d;
        mask_q  <= mask_d;
        rsel_q  <= rsel_d;
        tag_q   <= tag_d;
    end

    assign state  = state_q;
    assign result = res_q;
    assign tag    = tag_q;
endmodule

// File: rtl/vx_div_multi_unit.sv
// vx_div_multi_unit: round-robin allocation over divide engines with strictly in-order retire
module vx_div_multi_unit
    import vx_div_multi_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 4,
    parameter int NUM_UNITS = 2,
    parameter int TAG_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic                   is_signed,
    input  logic                   is_rem,
    input  logic [LANES-1:0]       lane_mask,
    input  logic [LANES*WIDTH-1:0] numer,
    input  logic [LANES*WIDTH-1:0] denom,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [LANES*WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]   tag_out
);
    localparam int PW = ptr_width(NUM_UNITS);
    localparam logic [PW-1:0] LAST = PW'(NUM_UNITS - 1);

    logic [PW-1:0] alloc_q, alloc_d, retire_q, retire_d;
    eng_state_e st [NUM_UNITS];
    logic [LANES*WIDTH-1:0] res [NUM_UNITS];
    logic [TAG_WIDTH-1:0] tags [NUM_UNITS];
    logic fire_in, fire_out;

    assign ready_in  = st[alloc_q] == IDLE;
    assign valid_out = st[retire_q] == DONE;
    assign result    = res[retire_q];
    assign tag_out   = tags[retire_q];
    assign fire_in   = valid_in && ready_in;
    assign fire_out  = valid_out && ready_out;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_eng
        vx_div_engine #(
            .WIDTH(WIDTH),
            .LANES(LANES),
            .TAG_WIDTH(TAG_WIDTH)
        ) u_eng (
            .clk(clk),
            .reset(reset),
            .start(fire_in && alloc_q == PW'(u)),
            .retire(fire_out && retire_q == PW'(u)),
            .is_signed(is_signed),
            .is_rem(is_rem),
            .lane_mask(lane_mask),
            .numer(numer),
            .denom(denom),
            .tag_in(tag_in),
            .state(st[u]),
            .result(res[u]),
            .tag(tags[u])
        );
    end

    always_comb begin
        alloc_d  = fire_in ? ((alloc_q == LAST) ? '0 : alloc_q + 1'b1) : alloc_q;
        retire_d = fire_out ? ((retire_q == LAST) ? '0 : retire_q + 1'b1) : retire_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_q  <= '0;
            retire_q <= '0;
        end else begin
            alloc_q  <= alloc_d;
            retire_q <= retire_d;
        end
    end
endmodule

// File: tb/tb_vx_div_multi_unit.sv
// tb_vx_div_multi_unit: randomized and directed checks of the divider against an arithmetic model
module tb_vx_div_multi_unit;
    localparam int W = 32, L = 4, NU = 2, TW = 16, RW = W * L;

    logic clk = 0, reset = 1, valid_in = 0, ready_in, is_signed = 0, is_rem = 0;
    logic [L-1:0] lane_mask = '0;
    logic [RW-1:0] numer = '0, denom = '0, result;
    logic [TW-1:0] tag_in = '0, tag_out;
    logic valid_out, ready_out = 1;

    typedef struct packed {
        logic [RW-1:0] res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    logic [TW-1:0] out_tags[$];
    int tests = 0, fails = 0, cyc = 0, last_fire = 0;
    logic hold = 0, rand_done = 0;
    logic [RW-1:0] held_res;
    logic [TW-1:0] held_tag;

    vx_div_multi_unit #(.WIDTH(W), .LANES(L), .NUM_UNITS(NU), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .is_signed(is_signed), .is_rem(is_rem), .lane_mask(lane_mask),
        .numer(numer), .denom(denom), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out), .result(result), .tag_out(tag_out)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] n, input logic [W-1:0] d, input bit s, input bit r);
        longint ns, ds, q, rm;
        if (d == 0) return r ? n : {W{1'b1}};
        if (!s) return r ? n % d : n / d;
        ns = $signed(n);
        ds = $signed(d);
        q  = ns / ds;
        rm = ns % ds;
        return r ? rm[W-1:0] : q[W-1:0];
    endfunction

    function automatic logic [RW-1:0] model(input bit s, input bit r, input logic [L-1:0] m,
                                            input logic [RW-1:0] n, input logic [RW-1:0] d);
        logic [RW-1:0] o = '0;
        for (int i = 0; i < L; i++)
            if (m[i]) o[i*W +: W] = ref_div(n[i*W +: W], d[i*W +: W], s, r);
        return o;
    endfunction

    function automatic logic [RW-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    function automatic logic [RW-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [RW-1:0] rnd_vec();
        logic [RW-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = rnd_op();
        return v;
    endfunction

    // Scoreboard: every output fire must match the oldest accepted request; stalled outputs must not move.
    initial forever begin
        @(negedge clk);
        if (reset || !valid_out) hold = 0;
        else begin
            if (hold) begin
                check("hold_result", result, held_res);
                check("hold_tag", tag_out, held_tag);
            end
            if (ready_out) begin
                hold = 0;
                if (sb.size() == 0) check("unexpected_output", valid_out, 0);
                else begin
                    e_cur = sb.pop_front();
                    check("result", result, e_cur.res);
                    check("tag", tag_out, e_cur.tag);
                    out_tags.push_back(tag_out);
                end
            end else begin
                hold = 1;
                held_res = result;
                held_tag = tag_out;
            end
        end
    end

    task automatic send(input bit s, input bit r, input logic [L-1:0] m,
                        input logic [RW-1:0] n, input logic [RW-1:0] d, input logic [TW-1:0] t);
        int k = 0;
        is_signed = s; is_rem = r; lane_mask = m; numer = n; denom = d; tag_in = t;
        valid_in = 1;
        @(negedge clk);
        while (!ready_in && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!ready_in) begin
            check("accept_timeout", ready_in, 1);
            valid_in = 0;
            return;
        end
        sb.push_back({model(s, r, m, n, d), t});
        last_fire = cyc + 1;
        @(posedge clk);
        #1 valid_in = 0;
    endtask

    task automatic wait_valid(output int lat);
        int k = 0;
        @(negedge clk);
        while (!valid_out && k < 100) begin
            @(negedge clk);
            k++;
        end
        lat = valid_out ? cyc - last_fire + 1 : -1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", RW'(sb.size()), 0);
    endtask

    task automatic directed(input string nm, input bit s, input bit r, input logic [L-1:0] m,
                            input logic [RW-1:0] n, input logic [RW-1:0] d, input logic [TW-1:0] t,
                            input logic [RW-1:0] want, input int want_lat);
        int lat;
        send(s, r, m, n, d, t);
        wait_valid(lat);
        check({nm, "_latency"}, RW'(lat), RW'(want_lat));
        check(nm, result, want);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f1, f2, f3;
        logic seen;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_valid_out", valid_out, 0);
        check("reset_ready_in", ready_in, 1);
        @(posedge clk);
        #1;

        directed("udiv", 0, 0, 4'hF, rep(100), rep(7), 16'h11, rep(14), W + 1);
        directed("urem", 0, 1, 4'hF, rep(100), rep(7), 16'h12, rep(2), W + 1);
        directed("sdiv", 1, 0, 4'hF, pack4(32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd20),
                 pack4(32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD), 16'h13,
                 pack4(32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFA), W + 1);
        directed("srem", 1, 1, 4'hF, pack4(32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd20),
                 pack4(32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD), 16'h14,
                 pack4(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd2), W + 1);
        directed("dz_div", 0, 0, 4'hF, rep(5), rep(0), 16'h15, rep(32'hFFFF_FFFF), 1);
        directed("dz_rem", 0, 1, 4'hF, rep(5), rep(0), 16'h16, rep(5), 1);
        directed("one_nonzero", 0, 0, 4'hF, rep(5), pack4(32'd7, 0, 0, 0), 16'h17,
                 pack4(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), W + 1);
        directed("masked_early", 0, 1, 4'b0101, rep(5), pack4(0, 32'd9, 0, 32'd9), 16'h18,
                 pack4(32'd5, 32'd0, 32'd5, 32'd0), 1);

        out_tags.delete();
        send(0, 0, 4'hF, rep(1000), rep(3), 16'd1);
        f1 = last_fire;
        send(0, 0, 4'hF, rep(1000), rep(3), 16'd2);
        f2 = last_fire;
        @(negedge clk);
        check("full_ready_in", ready_in, 0);
        @(posedge clk);
        #1;
        send(0, 0, 4'hF, rep(1000), rep(3), 16'd3);
        f3 = last_fire;
        check("second_accept_gap", RW'(f2 - f1), 1);
        check("third_accept_gap", RW'(f3 - f1), RW'(W + 2));
        wait_drain(200);
        check("order_123", {out_tags[0], out_tags[1], out_tags[2]}, {16'd1, 16'd2, 16'd3});

        @(posedge clk);
        #1;
        out_tags.delete();
        send(0, 0, 4'hF, rep(77), rep(5), 16'hA);
        send(0, 0, 4'hF, rep(77), rep(0), 16'hB);
        repeat (5) @(negedge clk);
        check("early_blocked", valid_out, 0);
        wait_drain(200);
        check("order_ab", {out_tags[0], out_tags[1]}, {16'hA, 16'hB});

        @(posedge clk);
        #1 ready_out = 0;
        send(0, 0, 4'hF, rep(81), rep(9), 16'h77);
        begin
            int lat;
            wait_valid(lat);
            check("stall_latency", RW'(lat), RW'(W + 1));
        end
        repeat (10) @(negedge clk);
        check("stall_valid", valid_out, 1);
        check("stall_result", result, rep(9));
        check("stall_tag", tag_out, 16'h77);
        @(posedge clk);
        #1 ready_out = 1;
        wait_drain(50);

        @(posedge clk);
        #1;
        send(0, 0, 4'hF, rep(1234), rep(11), 16'h55);
        repeat (10) @(posedge clk);
        #1 reset = 1;
        sb.delete();
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("midcalc_reset_valid", valid_out, 0);
        check("midcalc_reset_ready", ready_in, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | valid_out;
        end
        check("midcalc_reset_no_stale", seen, 0);

        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         rnd_vec(), rnd_vec(), 16'($urandom()));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 ready_out = ($urandom_range(0, 3) != 0);
                end
                ready_out = 1;
            end
        join
        wait_drain(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", fails);
        $fatal(1);
    end
endmodule

// File: doc/vx_div_multi_unit.md
Name: vx_div_multi_unit

Overview:
- Parametrised multi-engine iterative integer divider for the ALU M-extension path.
- Generalises the single serial divider to NUM_UNITS independent radix-2 engines. Up to NUM_UNITS divide warps are in flight concurrently, each spanning LANES lanes.
- Adds RISC-V corner-case handling (divide-by-zero, signed overflow) and a one-cycle early-out when every active lane has a zero divisor.
- Requests are allocated to engines round-robin. Results retire strictly in acceptance order through a valid/ready output.

Parameters:
- WIDTH, 32, operand/result bit width (32 or 64)
- LANES, 4, SIMD lanes per request
- NUM_UNITS, 2, number of divide engines (power of two, >=1)
- TAG_WIDTH, 16, opaque tag carried alongside each request

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  request valid
- ready_in  out  1  request accepted when valid_in && ready_in
- is_signed  in  1  signed divide/remainder
- is_rem  in  1  return remainder (else quotient)
- lane_mask  in  LANES  active lanes
- numer  in  LANES*WIDTH  dividends
- denom  in  LANES*WIDTH  divisors
- tag_in  in  TAG_WIDTH  request tag
- valid_out  out  1  result valid
- ready_out  in  1  downstream ready
- result  out  LANES*WIDTH  per-lane result
- tag_out  out  TAG_WIDTH  tag of the result

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: every engine goes IDLE; alloc_ptr=0 and retire_ptr=0; valid_out=0. result and tag_out are don't-care while valid_out=0.
- Reset mid-operation discards every in-flight request; nothing is emitted afterwards.
- Engine FSM states are IDLE, CALC, DONE.
  - IDLE->CALC on fire when the engine is the alloc_ptr target and the request is not an early-out.
  - IDLE->DONE on fire when the request is an early-out (all masked-in lanes have denom==0).
  - CALC->DONE after exactly WIDTH iterations; an internal counter counts WIDTH-1 down to 0.
  - DONE->IDLE on the output fire while retire_ptr selects this engine.
- ready_in = (engine[alloc_ptr] is IDLE). There is no combinational path from ready_out to ready_in.
- alloc_ptr increments modulo NUM_UNITS on each input fire. retire_ptr increments on each output fire.
- Output mux:
  - valid_out = engine[retire_ptr] in DONE.
  - result and tag_out come from engine[retire_ptr].
  - result and tag_out are held stable while valid_out && !ready_out.
- Latency, fire edge counted as edge 0:
  - Normal request: valid_out rises after edge WIDTH+1.
  - Early-out: valid_out rises after edge 1.
  - Both apply only when the engine is at the head of retire order; otherwise the result waits in DONE.
- Peak throughput is NUM_UNITS requests per WIDTH+2 cycles.
- Signed arithmetic:
  - Operate on absolute values.
  - Negate the quotient when the signs differ.
  - The remainder takes the sign of the dividend.
- Divide by zero, per lane: quotient = all ones; remainder = numer.
- Signed overflow (numer = MIN_INT, denom = -1): quotient = MIN_INT, remainder = 0.
- Masked-out lanes return 0 and do not block the early-out.
- One engine can retire and a different engine can accept in the same cycle.
- With NUM_UNITS==1, an engine freed by an output fire accepts again no earlier than the next cycle.

Decomposition:
- Shared package entries:
  - engine-state enum (IDLE/CALC/DONE);
  - DIV_ALL_ONES / MIN_INT constant helpers, parameterised by WIDTH;
  - a pointer-width localparam, CLOG2 with UP(NUM_UNITS).
- Sub-module vx_div_engine: one engine covering all LANES. It holds the FSM, iteration counter, partial remainder/quotient registers and sign fix-up.
- The top level handles allocation and retire pointers plus the output mux.

Test Plan:
- Unsigned 100/7, is_rem=0, then is_rem=1, WIDTH=32, LANES=4 same data -> result 14 on all lanes, then 2; valid_out exactly 33 cycles after fire.
- Signed -7/2 and 7/-2, quotient and remainder -> quotients -3 / -3; remainders -1 / 1. MIN_INT/-1 -> 0x80000000 with remainder 0.
- denom=0 on all active lanes with numer=5 -> quotient 0xFFFFFFFF / remainder 5; valid_out 1 cycle after fire. One nonzero lane -> full 33-cycle latency, and zero lanes still give 0xFFFFFFFF.
- NUM_UNITS=2: three back-to-back requests with tags 1,2,3 -> ready_in drops after the second. Tags emerge in order 1,2,3; the third is accepted only after engine 0 retires.
- Early-out tag B issued behind normal tag A -> B is held in DONE until A fires; order A,B.
- ready_out held low 10 cycles after valid_out -> result and tag stable. Reset pulse asserted mid-CALC -> valid_out=0 and ready_in=1 the next cycle; no stale result emitted.
